// File: rtl/gen_xy_sweep.sv
// XY sweep generator: stepped sawtooth/triangle ramp Q between CENTER-SPAN and CENTER+SPAN,
// with X/Y DAC code mapping, end-of-sweep pulse and sweep counter.
module gen_xy_sweep #(
    parameter int W      = 12,
    parameter int CENTER = 2000,
    parameter int SPAN   = 1000,
    parameter int STEP_W = 4,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st,
    input  logic [STEP_W-1:0] step,
    input  logic              mode_tri,
    input  logic              x_hold,
    input  logic [5:0]        x_off,
    input  logic              y_inv,
    output logic [W-1:0]      Q,
    output logic              dir,
    output logic              UP,
    output logic [W-1:0]      X,
    output logic [W-1:0]      Y,
    output logic              frame,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int LO_I = CENTER - SPAN;
    localparam int HI_I = CENTER + SPAN;

    if (SPAN < 1 || LO_I < 0 || HI_I >= (1 << W) || 2 * SPAN >= (1 << W) ||
        STEP_W < 1 || STEP_W > W) begin : g_bad_params
        $error("gen_xy_sweep: illegal parameter set");
    end

    localparam logic [W:0]   LO_E   = (W+1)'(LO_I);
    localparam logic [W:0]   HI_E   = (W+1)'(HI_I);
    localparam logic [W-1:0] LO_Q   = W'(LO_I);
    localparam logic [W-1:0] HI_Q   = W'(HI_I);
    localparam logic [W-1:0] CTR_Q  = W'(CENTER);
    localparam logic [W-2:0] SPAN_D = (W-1)'(SPAN);

    logic [W-1:0]      q_r;
    logic              dir_r;
    logic              frame_r;
    logic [FCNT_W-1:0] fcnt_r;

    logic [W-1:0]      q_nxt_s;
    logic              dir_nxt_s;
    logic              frame_nxt_s;
    logic [FCNT_W-1:0] fcnt_nxt_s;

    logic [STEP_W-1:0] s_s;
    logic [W:0]        s_e_s;
    logic [W:0]        q_e_s;
    logic [W:0]        up_sum_s;
    logic [W:0]        lo_lim_s;

    logic              up_s;
    logic [W-2:0]      dq_s;
    logic [W-2:0]      y_base_s;
    logic [W-1:0]      xo_s;

    // Effective step and W+1-bit operands so neither add nor subtract can wrap
    always_comb begin
        s_s      = (step == {STEP_W{1'b0}}) ? {{(STEP_W-1){1'b0}}, 1'b1} : step;
        s_e_s    = (W+1)'(s_s);
        q_e_s    = {1'b0, q_r};
        up_sum_s = q_e_s + s_e_s;
        lo_lim_s = LO_E + s_e_s;
    end

    // Next ramp position, direction, frame pulse and sweep count
    always_comb begin
        q_nxt_s     = q_r;
        dir_nxt_s   = dir_r;
        frame_nxt_s = 1'b0;
        fcnt_nxt_s  = fcnt_r;
        if (st) begin
            if (!mode_tri) begin
                dir_nxt_s = 1'b1;
                if (q_r == HI_Q) begin
                    q_nxt_s     = LO_Q;
                    frame_nxt_s = 1'b1;
                    fcnt_nxt_s  = fcnt_r + {{(FCNT_W-1){1'b0}}, 1'b1};
                end else if (up_sum_s >= HI_E) begin
                    q_nxt_s = HI_Q;
                end else begin
                    q_nxt_s = up_sum_s[W-1:0];
                end
            end else if (dir_r) begin
                if (up_sum_s >= HI_E) begin
                    q_nxt_s   = HI_Q;
                    dir_nxt_s = 1'b0;
                end else begin
                    q_nxt_s = up_sum_s[W-1:0];
                end
            end else begin
                // Bounce at the bottom as soon as another step would reach or pass LO
                if (q_e_s <= lo_lim_s) begin
                    q_nxt_s     = LO_Q;
                    dir_nxt_s   = 1'b1;
                    frame_nxt_s = 1'b1;
                    fcnt_nxt_s  = fcnt_r + {{(FCNT_W-1){1'b0}}, 1'b1};
                end else begin
                    q_nxt_s = q_r - s_s;
                end
            end
        end else begin
            frame_nxt_s = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= CTR_Q;
            dir_r   <= 1'b1;
            frame_r <= 1'b0;
            fcnt_r  <= {FCNT_W{1'b0}};
        end else begin
            q_r     <= q_nxt_s;
            dir_r   <= dir_nxt_s;
            frame_r <= frame_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
        end
    end

    // DAC code mapping: Y follows distance from centre, X tracks Q or a held offset
    always_comb begin
        up_s     = (q_r >= CTR_Q);
        dq_s     = up_s ? (W-1)'(q_r - CTR_Q) : (W-1)'(CTR_Q - q_r);
        y_base_s = y_inv ? (SPAN_D - dq_s) : dq_s;
        xo_s     = W'({x_off, 5'b00000});
    end

    assign Q         = q_r;
    assign dir       = dir_r;
    assign frame     = frame_r;
    assign frame_cnt = fcnt_r;
    assign UP        = up_s;
    assign Y         = {y_base_s, 1'b0};
    assign X         = x_hold ? (CTR_Q - xo_s) : q_r;

endmodule
